// File: rtl/stream_sync_ctrl_if.sv
// Control/status bundle between the stream-sync controller and its environment.
// The slave side is the controller; the master side drives requests and SOF/control strobes.
interface stream_sync_ctrl_if;
    logic        start;
    logic        clear_err;
    logic        frame_start_new;
    logic        frame_start_ref;
    logic        control_new;
    logic        control_ref;
    logic        sync_rst;
    logic        align_enable;
    logic        locked;
    logic        timeout_err;
    logic        resync_err;
    logic [15:0] frame_count;
    logic [7:0]  resync_count;

    modport master (
        output start, clear_err, frame_start_new, frame_start_ref,
               control_new, control_ref, sync_rst,
        input  align_enable, locked, timeout_err, resync_err,
               frame_count, resync_count
    );

    modport slave (
        input  start, clear_err, frame_start_new, frame_start_ref,
               control_new, control_ref, sync_rst,
        output align_enable, locked, timeout_err, resync_err,
               frame_count, resync_count
    );
endinterface

// File: rtl/stream_sync_ctrl.sv
// Alignment supervisor for a camera stream against a reference stream: arms the
// aligner, tracks lock, counts aligned frames and lock losses, and latches faults.
module stream_sync_ctrl #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000,
    parameter logic [7:0]  MAX_RESYNC     = 8'd4
) (
    input  logic               clk,
    input  logic               reset,
    stream_sync_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ARM, LOCKED, FAULT} state_t;

    state_t      state_q, state_d;
    logic [23:0] wait_q, wait_d;
    logic [15:0] frame_q, frame_d;
    logic [7:0]  resync_q, resync_d;
    logic [7:0]  resync_inc;
    logic        tmo_err_q, tmo_err_d;
    logic        rsy_err_q, rsy_err_d;
    logic        align_en_q, locked_q;
    logic        lock_hit, stream_drop, tmo_hit;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign lock_hit    = bus.sync_rst || (bus.frame_start_new && bus.frame_start_ref);
    assign stream_drop = !bus.control_new || !bus.control_ref;
    assign tmo_hit     = (wait_q == TIMEOUT_CYCLES - 24'd1);
    assign resync_inc  = sat_inc8(resync_q);

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        frame_d   = frame_q;
        resync_d  = resync_q;
        tmo_err_d = tmo_err_q;
        rsy_err_d = rsy_err_q;

        // A flag being raised this cycle takes precedence over a concurrent clear.
        if (bus.clear_err) begin
            tmo_err_d = 1'b0;
            rsy_err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ARM;
                    wait_d  = '0;
                end
            end
            ARM: begin
                if (!bus.start) begin
                    state_d = IDLE;
                end else if (lock_hit) begin
                    state_d = LOCKED;
                end else if (tmo_hit) begin
                    state_d   = FAULT;
                    tmo_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 24'd1;
                end
            end
            LOCKED: begin
                if (bus.frame_start_new) frame_d = frame_q + 16'd1;
                if (!bus.start) begin
                    state_d = IDLE;
                end else if (stream_drop) begin
                    resync_d = resync_inc;
                    if (resync_inc == MAX_RESYNC) begin
                        state_d   = FAULT;
                        rsy_err_d = 1'b1;
                    end else begin
                        state_d = ARM;
                        wait_d  = '0;
                    end
                end
            end
            FAULT: begin
                if (bus.clear_err) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Every session statistic restarts whenever the controller sits in IDLE.
        if (state_d == IDLE) begin
            wait_d   = '0;
            frame_d  = '0;
            resync_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            frame_q    <= '0;
            resync_q   <= '0;
            tmo_err_q  <= 1'b0;
            rsy_err_q  <= 1'b0;
            align_en_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            frame_q    <= frame_d;
            resync_q   <= resync_d;
            tmo_err_q  <= tmo_err_d;
            rsy_err_q  <= rsy_err_d;
            align_en_q <= (state_d == ARM) || (state_d == LOCKED);
            locked_q   <= (state_d == LOCKED);
        end
    end

    assign bus.align_enable = align_en_q;
    assign bus.locked       = locked_q;
    assign bus.timeout_err  = tmo_err_q;
    assign bus.resync_err   = rsy_err_q;
    assign bus.frame_count  = frame_q;
    assign bus.resync_count = resync_q;

endmodule

// File: tb/tb_stream_sync_ctrl.sv
// Directed and randomized checks of stream_sync_ctrl against a cycle-level
// behavioural model of the alignment rules.
module tb_stream_sync_ctrl;
    localparam int TMO  = 16;
    localparam int MAXR = 4;
    localparam int S_IDLE = 0, S_ARM = 1, S_LOCK = 2, S_FAULT = 3;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    // behavioural model
    int m_st, m_wait, m_fc, m_rc;
    bit m_te, m_re;

    stream_sync_ctrl_if bus();

    stream_sync_ctrl #(.TIMEOUT_CYCLES(24'(TMO)), .MAX_RESYNC(8'(MAXR))) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_wait = 0; m_fc = 0; m_rc = 0; m_te = 0; m_re = 0;
    endtask

    // One clock of the rules, applied to the inputs seen at the edge.
    task automatic model_edge();
        int  nst;
        bit  raise_te, raise_re;
        if (reset) begin
            model_reset();
            return;
        end
        nst = m_st; raise_te = 0; raise_re = 0;
        if (m_st == S_IDLE) begin
            if (bus.start) begin nst = S_ARM; m_wait = 0; end
        end else if (m_st == S_FAULT) begin
            if (bus.clear_err) nst = S_IDLE;
        end else if (!bus.start) begin
            nst = S_IDLE;
        end else if (m_st == S_ARM) begin
            if (bus.sync_rst || (bus.frame_start_new && bus.frame_start_ref)) nst = S_LOCK;
            else if (m_wait == TMO - 1) begin nst = S_FAULT; raise_te = 1; end
            else m_wait = m_wait + 1;
        end else if (!bus.control_new || !bus.control_ref) begin
            m_rc = (m_rc >= 255) ? 255 : m_rc + 1;
            if (m_rc == MAXR) begin nst = S_FAULT; raise_re = 1; end
            else begin nst = S_ARM; m_wait = 0; end
        end
        if (m_st == S_LOCK && bus.frame_start_new) m_fc = (m_fc + 1) % 65536;
        m_te = raise_te ? 1'b1 : (bus.clear_err ? 1'b0 : m_te);
        m_re = raise_re ? 1'b1 : (bus.clear_err ? 1'b0 : m_re);
        if (nst == S_IDLE) begin m_wait = 0; m_fc = 0; m_rc = 0; end
        m_st = nst;
    endtask

    task automatic chk_all(input string ctx);
        chk({ctx, ".align"},  32'(bus.align_enable), 32'(m_st == S_ARM || m_st == S_LOCK));
        chk({ctx, ".locked"}, 32'(bus.locked),       32'(m_st == S_LOCK));
        chk({ctx, ".tmo"},    32'(bus.timeout_err),  32'(m_te));
        chk({ctx, ".rsy"},    32'(bus.resync_err),   32'(m_re));
        chk({ctx, ".fc"},     32'(bus.frame_count),  32'(m_fc));
        chk({ctx, ".rc"},     32'(bus.resync_count), 32'(m_rc));
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        chk_all(ctx);
    endtask

    task automatic idle_inputs();
        bus.clear_err = 0; bus.frame_start_new = 0; bus.frame_start_ref = 0;
        bus.control_new = 1; bus.control_ref = 1; bus.sync_rst = 0;
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        bus.start = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        chk_all("reset");
        step("reset_hold");

        // Lock path; start already high while reset is released
        bus.start = 1'b1;
        #2 reset = 1'b0;
        #1 chk("rel_no_arm", 32'(bus.align_enable), 32'd0);
        step("arm_entry");
        chk("arm_align", 32'(bus.align_enable), 32'd1);
        for (int i = 0; i < 9; i++) step("arm_wait");
        bus.sync_rst = 1; step("lock"); bus.sync_rst = 0;
        chk("lock_locked", 32'(bus.locked), 32'd1);
        for (int i = 0; i < 3; i++) begin
            bus.frame_start_new = 1; step("sof"); bus.frame_start_new = 0; step("sof_gap");
        end
        chk("lock_fc3", 32'(bus.frame_count), 32'd3);

        // Stop overrides a simultaneous stream drop
        bus.start = 0; bus.control_new = 0; step("stop_prio");
        bus.control_new = 1;
        chk("stop_rc", 32'(bus.resync_count), 32'd0);
        chk("stop_locked", 32'(bus.locked), 32'd0);

        // Timeout into FAULT, then clear with start held high
        bus.start = 1;
        for (int i = 0; i < TMO + 1; i++) step("tmo_run");
        chk("tmo_flag", 32'(bus.timeout_err), 32'd1);
        chk("tmo_align", 32'(bus.align_enable), 32'd0);
        bus.start = 0; step("fault_hold");
        chk("fault_stays", 32'(bus.timeout_err), 32'd1);
        bus.start = 1; bus.clear_err = 1; step("clear"); bus.clear_err = 0;
        chk("clear_flag", 32'(bus.timeout_err), 32'd0);
        chk("clear_idle", 32'(bus.align_enable), 32'd0);
        step("rearm");
        chk("rearm_align", 32'(bus.align_enable), 32'd1);

        // Lock on the final ARM cycle beats the timeout
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_st == S_ARM && m_wait == TMO - 1) found = 1;
            else step("ltmo_walk");
        end
        chk("ltmo_reach", 32'(found), 32'd1);
        bus.sync_rst = 1; step("ltmo"); bus.sync_rst = 0;
        chk("ltmo_locked", 32'(bus.locked), 32'd1);
        chk("ltmo_flag", 32'(bus.timeout_err), 32'd0);

        // Repeated reference drops reach the resync limit
        for (int i = 0; i < MAXR; i++) begin
            bus.control_ref = 0; step("drop"); bus.control_ref = 1;
            if (i < MAXR - 1) begin bus.sync_rst = 1; step("relock"); bus.sync_rst = 0; end
        end
        chk("rsy_count", 32'(bus.resync_count), 32'd4);
        chk("rsy_flag", 32'(bus.resync_err), 32'd1);
        chk("rsy_align", 32'(bus.align_enable), 32'd0);
        bus.clear_err = 1; step("rsy_clear"); bus.clear_err = 0;
        step("rsy_rearm");

        // Asynchronous reset while LOCKED with five frames counted
        bus.sync_rst = 1; step("r_lock"); bus.sync_rst = 0;
        for (int i = 0; i < 5; i++) begin
            bus.frame_start_new = 1; step("r_sof"); bus.frame_start_new = 0;
        end
        chk("r_fc5", 32'(bus.frame_count), 32'd5);
        #2 reset = 1'b1;
        #1 model_reset();
        chk_all("async_rst");
        step("rst_hold");
        reset = 1'b0;
        step("post_rst_arm");
        bus.sync_rst = 1; step("post_rst_lock"); bus.sync_rst = 0;
        chk("post_rst_fc", 32'(bus.frame_count), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            bus.start           = ($urandom_range(99) < 96);
            bus.clear_err       = ($urandom_range(99) < 3);
            bus.frame_start_new = ($urandom_range(99) < 30);
            bus.frame_start_ref = ($urandom_range(99) < 20);
            bus.control_new     = ($urandom_range(99) < 97);
            bus.control_ref     = ($urandom_range(99) < 97);
            bus.sync_rst        = ($urandom_range(99) < 4);
            step("rand");
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stream_sync_ctrl.md
STREAM_SYNC_CTRL -- requirements
Module: stream_sync_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd4000000: max cycles in ARM before FAULT.
REQ-002 Parameter MAX_RESYNC, default 8'd4: resync count that forces FAULT.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level; 1 = alignment requested, 0 = stop.
REQ-006 clear_err  input  1  level; clears FAULT and error flags.
REQ-007 frame_start_new  input  1  camera SOF, one-cycle pulse.
REQ-008 frame_start_ref  input  1  reference SOF, one-cycle pulse.
REQ-009 control_new  input  1  camera stream active (0 = dropped).
REQ-010 control_ref  input  1  reference stream active (0 = dropped).
REQ-011 sync_rst  input  1  aligner lock pulse.
REQ-012 align_enable  output  1  drives aligner enable.
REQ-013 locked  output  1  streams aligned.
REQ-014 timeout_err  output  1  sticky ARM timeout flag.
REQ-015 resync_err  output  1  sticky excessive-resync flag.
REQ-016 frame_count  output  16  aligned camera frames since lock from IDLE.
REQ-017 resync_count  output  8  lock losses since lock from IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ARM, LOCKED, FAULT; all outputs registered.
REQ-019 IDLE: align_enable=0, locked=0; start=1 -> ARM next cycle; frame_count, resync_count, wait counter cleared on entry.
REQ-020 ARM: align_enable=1, locked=0; 24-bit wait counter increments each cycle from 0.
REQ-021 ARM -> LOCKED on sync_rst=1, or on frame_start_new=1 and frame_start_ref=1 in the same cycle.
REQ-022 ARM -> FAULT with timeout_err=1 when wait counter equals TIMEOUT_CYCLES-1 and no lock condition that cycle; lock wins over timeout in the same cycle.
REQ-023 LOCKED: align_enable=1, locked=1; frame_count +1 per frame_start_new pulse, wraps 16'hFFFF -> 0.
REQ-024 LOCKED -> ARM on control_new=0 or control_ref=0; resync_count +1 (saturates at 8'hFF); wait counter cleared.
REQ-025 If that increment makes resync_count equal MAX_RESYNC, transition SHALL be to FAULT with resync_err=1 instead of ARM.
REQ-026 FAULT: align_enable=0, locked=0; error flags held; leave to IDLE only when clear_err=1, which also clears both flags.
REQ-027 start=0 in ARM or LOCKED -> IDLE next cycle, overriding every other transition; error flags unaffected.
REQ-028 start=0 does not exit FAULT; clear_err=1 with start=1 -> IDLE, then ARM one cycle later.
REQ-029 clear_err outside FAULT SHALL clear timeout_err and resync_err only.
REQ-030 SOF pulses outside LOCKED SHALL NOT change frame_count.
REQ-031 Counter arithmetic unsigned, fixed width, no overflow flags.

Reset
REQ-032 reset=1 SHALL asynchronously force IDLE, all outputs 0, all counters 0, flags 0.
REQ-033 Reset asserted mid-ARM or mid-LOCKED SHALL drop align_enable within the same reset assertion, no partial-cycle retention.
REQ-034 First transition out of IDLE occurs no earlier than the first rising edge after reset deasserts.

Verification
REQ-035 Lock path: start=1, sync_rst pulse 10 cycles later -> align_enable=1 from cycle 2, locked=1 the cycle after the pulse; 3 frame_start_new pulses -> frame_count=3.
REQ-036 Timeout: TIMEOUT_CYCLES=16, start=1, no lock -> FAULT, timeout_err=1, align_enable=0 after 16 ARM cycles; clear_err=1 -> IDLE, flag 0.
REQ-037 Lock vs timeout: sync_rst on the final ARM cycle -> LOCKED, timeout_err=0.
REQ-038 Resync limit: MAX_RESYNC=4, four control_ref=0 drops with relock between -> resync_count=4, FAULT, resync_err=1.
REQ-039 Stop priority: in LOCKED, start=0 same cycle as control_new=0 -> IDLE, resync_count unchanged then cleared on IDLE entry.
REQ-040 Reset mid-LOCKED with frame_count=5 -> all outputs 0 immediately; relock after release restarts frame_count at 0.
